// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch engine. Issues single-beat AXI4 reads at a sequential
//   fetch PC, buffers returned words with their addresses in a small FIFO,
//   and hands them to a consumer over a valid/ready handshake. A redirect
//   flushes the buffer, retargets the PC and drops any read in flight. A
//   bus error stops fetching until the next redirect.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   CEXEC                 fetch enable
//   REDIRECT, REDIRECT_PC flush strobe and jump target (word aligned here)
//   INST_VALID/READY      consumer handshake, INST / INST_PC = buffer head
//   STAT                  [1:0] state, [2] sticky error, [3] full, [7:4] occupancy
//   M_AXI_AR*             read address channel (single beat, 32-bit, INCR)
//   M_AXI_R*              read data channel
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC                = 32'h2000_0000,
    parameter int unsigned FIFO_DEPTH              = 4,
    parameter int unsigned C_M_AXI_ADDR_WIDTH      = 32,
    parameter int unsigned C_M_AXI_THREAD_ID_WIDTH = 1
) (
    input  logic                               CLK,
    input  logic                               RST,

    input  logic                               CEXEC,
    input  logic                               REDIRECT,
    input  logic [31:0]                        REDIRECT_PC,

    output logic                               INST_VALID,
    input  logic                               INST_READY,
    output logic [31:0]                        INST,
    output logic [31:0]                        INST_PC,

    output logic [7:0]                         STAT,

    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,

    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
    input  logic [31:0]                        M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY
);

    localparam int unsigned     AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned     CW        = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [1:0]      RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ADDR    = 2'd1,
        ST_DATA    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          redir_pend_q, redir_pend_d;
    logic          err_q, err_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   mem_inst_q [FIFO_DEPTH];
    logic [31:0]   mem_pc_q   [FIFO_DEPTH];

    logic          ar_hs;
    logic          r_hs;
    logic          push;
    logic          pop;
    logic          buf_full;

    logic          unused_inputs;
    assign unused_inputs = ^{M_AXI_RID, M_AXI_RLAST, REDIRECT_PC[1:0]};

    assign ar_hs    = arvalid_q && M_AXI_ARREADY;
    assign r_hs     = rready_q && M_AXI_RVALID;
    assign buf_full = (count_q == DEPTH_C);

    // Pops are suppressed during a redirect: the flush takes precedence
    assign pop = (count_q != '0) && INST_READY && !REDIRECT;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        redir_pend_d = redir_pend_q;
        err_d        = err_q;
        push         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Only one read is ever outstanding, so a free slot now is
                // guaranteed to still be free when the data returns.
                if (!REDIRECT && CEXEC && !err_q && (count_q < DEPTH_C)) begin
                    state_d  = ST_ADDR;
                    req_pc_d = fetch_pc_q;
                end
            end
            ST_ADDR: begin
                // A redirect cannot withdraw ARVALID; remember it and throw
                // the data away once the address has been accepted.
                if (ar_hs) begin
                    redir_pend_d = 1'b0;
                    if (REDIRECT || redir_pend_q) begin
                        state_d = ST_DISCARD;
                    end else begin
                        state_d    = ST_DATA;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (REDIRECT) begin
                    redir_pend_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (REDIRECT) begin
                    state_d = r_hs ? ST_IDLE : ST_DISCARD;
                end else if (r_hs) begin
                    state_d = ST_IDLE;
                    if (M_AXI_RRESP == RESP_OKAY) begin
                        push = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (r_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (REDIRECT) begin
            fetch_pc_d = {REDIRECT_PC[31:2], 2'b00};
            err_d      = 1'b0;
        end

        arvalid_d = (state_d == ST_ADDR);
        rready_d  = (state_d == ST_DATA) || (state_d == ST_DISCARD);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (REDIRECT) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= '0;
            redir_pend_q <= 1'b0;
            err_q        <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            redir_pend_q <= redir_pend_d;
            err_q        <= err_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // Buffer storage carries no reset; occupancy alone qualifies the head
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            mem_inst_q[wr_ptr_q] <= M_AXI_RDATA;
            mem_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign INST_VALID    = (count_q != '0);
    assign INST          = mem_inst_q[rd_ptr_q];
    assign INST_PC       = mem_pc_q[rd_ptr_q];

    assign STAT          = {4'(count_q), buf_full, err_q, state_q};

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'(req_pc_q);
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A behavioural AXI slave returns the read
//   address as data (optionally with an error response or stalls). Stimulus
//   pushes hand-computed instruction addresses and AR addresses into queues;
//   independent monitors pop and compare when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        CEXEC;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        INST_VALID;
    logic        INST_READY;
    logic [31:0] INST;
    logic [31:0] INST_PC;
    logic [7:0]  STAT;
    logic [0:0]  M_AXI_ARID;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [0:0]  M_AXI_RID;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    fetch_unit #(
        .RESET_PC               (32'h2000_0000),
        .FIFO_DEPTH             (4),
        .C_M_AXI_ADDR_WIDTH     (32),
        .C_M_AXI_THREAD_ID_WIDTH(1)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .CEXEC        (CEXEC),
        .REDIRECT     (REDIRECT),
        .REDIRECT_PC  (REDIRECT_PC),
        .INST_VALID   (INST_VALID),
        .INST_READY   (INST_READY),
        .INST         (INST),
        .INST_PC      (INST_PC),
        .STAT         (STAT),
        .M_AXI_ARID   (M_AXI_ARID),
        .M_AXI_ARADDR (M_AXI_ARADDR),
        .M_AXI_ARLEN  (M_AXI_ARLEN),
        .M_AXI_ARSIZE (M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID    (M_AXI_RID),
        .M_AXI_RDATA  (M_AXI_RDATA),
        .M_AXI_RRESP  (M_AXI_RRESP),
        .M_AXI_RLAST  (M_AXI_RLAST),
        .M_AXI_RVALID (M_AXI_RVALID),
        .M_AXI_RREADY (M_AXI_RREADY)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ar_exp[$];

    int          ar_stall = 0;
    int          r_stall  = 0;
    int          ar_count = 0;
    bit          err_en   = 0;
    logic [31:0] err_addr = 32'h0;
    bit          r_pend   = 0;
    logic [31:0] r_addr   = 32'h0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AXI slave: decisions made on the falling edge hold through the next
    // rising edge, so a handshake decided here completes at that edge.
    initial begin
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RDATA   = 32'h0;
        M_AXI_RRESP   = 2'b00;
        M_AXI_RLAST   = 1'b0;
        M_AXI_RID     = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                M_AXI_ARREADY = 1'b0;
                M_AXI_RVALID  = 1'b0;
                M_AXI_RLAST   = 1'b0;
                r_pend        = 0;
                r_stall       = 0;
            end else begin
                if (r_pend) begin
                    if (r_stall > 0) begin
                        r_stall--;
                        M_AXI_RVALID = 1'b0;
                    end else begin
                        M_AXI_RVALID = 1'b1;
                        M_AXI_RDATA  = r_addr;
                        M_AXI_RRESP  = (err_en && r_addr == err_addr) ? 2'b10 : 2'b00;
                        M_AXI_RLAST  = 1'b1;
                        if (M_AXI_RREADY) r_pend = 0;
                    end
                end else begin
                    M_AXI_RVALID = 1'b0;
                    M_AXI_RLAST  = 1'b0;
                end
                if (M_AXI_ARVALID) begin
                    if (ar_stall > 0) begin
                        M_AXI_ARREADY = 1'b0;
                        ar_stall--;
                    end else begin
                        M_AXI_ARREADY = 1'b1;
                        r_pend   = 1;
                        r_addr   = M_AXI_ARADDR;
                        ar_count++;
                        if (ar_exp.size() > 0) check("araddr", M_AXI_ARADDR, ar_exp.pop_front());
                    end
                end else begin
                    M_AXI_ARREADY = 1'b0;
                end
            end
        end
    end

    // Instruction monitor: a pop happens at the next rising edge
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge CLK);
            if (!RST && !REDIRECT && INST_VALID && INST_READY) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL inst_unexpected: got pc %h data %h expected none", INST_PC, INST);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", INST_PC, e);
                    check("inst_data", INST, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        REDIRECT    = 1'b1;
        REDIRECT_PC = pc;
        exp_q.delete();
        tick(1);
        REDIRECT    = 1'b0;
    endtask

    task automatic stop_and_flush();
        CEXEC      = 1'b0;
        INST_READY = 1'b0;
        tick(8);
        ar_exp.delete();
        do_redirect(32'h2000_0000);
        tick(6);
        ar_stall = 0;
        r_stall  = 0;
        err_en   = 0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int start;
        RST         = 1'b1;
        CEXEC       = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;
        INST_READY  = 1'b0;
        tick(3);
        check("rst_stat", STAT, 8'h00);
        check("rst_arvalid", M_AXI_ARVALID, 0);
        check("rst_rready", M_AXI_RREADY, 0);
        check("rst_inst_valid", INST_VALID, 0);
        RST = 1'b0;
        tick(1);

        // Sequential fetch from reset PC
        ar_exp.push_back(32'h2000_0000);
        ar_exp.push_back(32'h2000_0004);
        ar_exp.push_back(32'h2000_0008);
        exp_q.push_back(32'h2000_0000);
        exp_q.push_back(32'h2000_0004);
        exp_q.push_back(32'h2000_0008);
        CEXEC      = 1'b1;
        INST_READY = 1'b1;
        n = 0;
        while (!INST_VALID && n < 20) begin
            tick(1);
            n++;
        end
        check("first_valid_latency_ok", (n >= 2 && n <= 4), 1);
        wait_drain("seq_drain", 40);
        stop_and_flush();

        // Buffer fills with consumer stalled
        start = ar_count;
        exp_q.push_back(32'h2000_0000);
        exp_q.push_back(32'h2000_0004);
        exp_q.push_back(32'h2000_0008);
        exp_q.push_back(32'h2000_000C);
        exp_q.push_back(32'h2000_0010);
        INST_READY = 1'b0;
        CEXEC      = 1'b1;
        tick(30);
        check("full_reads", ar_count - start, 4);
        check("full_stat", STAT, 8'h48);
        check("full_arvalid", M_AXI_ARVALID, 0);
        INST_READY = 1'b1;
        tick(1);
        INST_READY = 1'b0;
        tick(12);
        check("refill_reads", ar_count - start, 5);
        check("refill_stat", STAT, 8'h48);
        CEXEC      = 1'b0;
        INST_READY = 1'b1;
        wait_drain("full_drain", 20);
        stop_and_flush();

        // Redirect while address is stalled
        ar_stall = 100;
        ar_exp.push_back(32'h2000_0000);
        ar_exp.push_back(32'h2000_0100);
        CEXEC      = 1'b1;
        INST_READY = 1'b1;
        n = 0;
        while (!M_AXI_ARVALID && n < 10) begin
            tick(1);
            n++;
        end
        check("stall_arvalid", M_AXI_ARVALID, 1);
        tick(2);
        ar_stall = 3;
        do_redirect(32'h2000_0103);
        for (int i = 0; i < 3; i++) begin
            check("held_arvalid", M_AXI_ARVALID, 1);
            check("held_araddr", M_AXI_ARADDR, 32'h2000_0000);
            tick(1);
        end
        exp_q.push_back(32'h2000_0100);
        wait_drain("redir_drain", 30);
        stop_and_flush();

        // Bus error halts fetching, redirect recovers
        err_en   = 1;
        err_addr = 32'h2000_0008;
        start    = ar_count;
        ar_exp.push_back(32'h2000_0000);
        ar_exp.push_back(32'h2000_0004);
        ar_exp.push_back(32'h2000_0008);
        exp_q.push_back(32'h2000_0000);
        exp_q.push_back(32'h2000_0004);
        INST_READY = 1'b0;
        CEXEC      = 1'b1;
        tick(25);
        check("err_stat", STAT, 8'h24);
        check("err_reads", ar_count - start, 3);
        check("err_arvalid", M_AXI_ARVALID, 0);
        INST_READY = 1'b1;
        wait_drain("err_keep_drain", 10);
        tick(5);
        check("err_no_more_reads", ar_count - start, 3);
        err_en = 0;
        do_redirect(32'h2000_0000);
        check("err_cleared", STAT[2], 0);
        ar_exp.push_back(32'h2000_0000);
        exp_q.push_back(32'h2000_0000);
        wait_drain("resume_drain", 20);
        stop_and_flush();

        // Reset in the middle of a data phase
        r_stall    = 100;
        CEXEC      = 1'b1;
        INST_READY = 1'b1;
        n = 0;
        while (STAT[1:0] != 2'd2 && n < 10) begin
            tick(1);
            n++;
        end
        check("reach_data", STAT[1:0], 2);
        RST = 1'b1;
        tick(1);
        check("midrst_stat", STAT, 8'h00);
        check("midrst_rready", M_AXI_RREADY, 0);
        check("midrst_inst_valid", INST_VALID, 0);
        check("midrst_arvalid", M_AXI_ARVALID, 0);
        RST     = 1'b0;
        r_stall = 0;
        exp_q.delete();
        ar_exp.push_back(32'h2000_0000);
        exp_q.push_back(32'h2000_0000);
        wait_drain("post_rst_drain", 20);
        stop_and_flush();

        // PC wrap at top of address space, misaligned target
        do_redirect(32'hFFFF_FFFE);
        ar_exp.push_back(32'hFFFF_FFFC);
        ar_exp.push_back(32'h0000_0000);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        CEXEC      = 1'b1;
        INST_READY = 1'b1;
        wait_drain("wrap_drain", 30);
        check("wrap_ar_consumed", ar_exp.size(), 0);
        stop_and_flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
